// File: rtl/tensor_host_pkg.sv
// rtl/tensor_host_pkg.sv - shared constants, instruction encodings and state enum (HOST_CLEAR_ON_START_EN adds CLEAR/RESET)
package tensor_host_pkg;

  localparam int OPSEL_W     = 3;
  localparam int NUM_ELEMS   = 9;
  localparam int WAIT_CYCLES = 5;

  localparam logic [4:0] ADDR_A_BASE = 5'd0;
  localparam logic [4:0] ADDR_B_BASE = 5'd9;
  localparam logic [4:0] ADDR_R_BASE = 5'd0;

  localparam logic [4:0] LOAD_LAST = 5'd17;
  localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYCLES - 1);
  localparam logic [4:0] READ_LAST = 5'(NUM_ELEMS - 1);

  localparam logic [1:0] OPC_READ    = 2'b00;
  localparam logic [1:0] OPC_LOAD    = 2'b01;
  localparam logic [1:0] OPC_OPERATE = 2'b10;
  localparam logic [3:0] READ_TAG    = 4'b1000;

  localparam logic [15:0] INSTR_NOP = 16'h0000;
`ifdef HOST_CLEAR_ON_START_EN
  localparam logic [15:0] INSTR_RESET = 16'h000C;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
`ifdef HOST_CLEAR_ON_START_EN
    ST_CLEAR   = 3'd1,
`endif
    ST_LOAD    = 3'd2,
    ST_OPERATE = 3'd3,
    ST_WAIT    = 3'd4,
    ST_READ    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/tensor_core_host_sequencer_if.sv
// rtl/tensor_core_host_sequencer_if.sv - host job and cpu instruction signals between host and sequencer
interface tensor_core_host_sequencer_if;
  logic        start_in;
  logic [2:0]  operation_select_in;
  logic [71:0] operand_a_in;
  logic [71:0] operand_b_in;
  logic [15:0] instruction_out;
  logic [7:0]  cpu_output_in;
  logic        busy_out;
  logic        done_out;
  logic [71:0] result_out;
  logic        result_valid_out;

  modport master (
    output start_in, operation_select_in, operand_a_in, operand_b_in, cpu_output_in,
    input  instruction_out, busy_out, done_out, result_out, result_valid_out
  );

  modport slave (
    input  start_in, operation_select_in, operand_a_in, operand_b_in, cpu_output_in,
    output instruction_out, busy_out, done_out, result_out, result_valid_out
  );
endinterface

// File: rtl/tensor_instruction_encoder.sv
// rtl/tensor_instruction_encoder.sv - combinational cpu instruction word builder (HOST_CLEAR_ON_START_EN adds RESET)
module tensor_instruction_encoder
  import tensor_host_pkg::*;
(
  input  state_t             state_i,
  input  logic [4:0]         index_i,
  input  logic [7:0]         data_i,
  input  logic [OPSEL_W-1:0] opsel_i,
  output logic [15:0]        instr_o
);

  // Map the sequencer state to the word the cpu executes in that cycle
  always_comb begin
    instr_o = INSTR_NOP;
    case (state_i)
`ifdef HOST_CLEAR_ON_START_EN
      ST_CLEAR:   instr_o = INSTR_RESET;
`endif
      ST_LOAD:    instr_o = {index_i, data_i, 1'b0, OPC_LOAD};
      ST_OPERATE: instr_o = {11'b0, opsel_i, OPC_OPERATE};
      ST_READ:    instr_o = {5'b0, ADDR_R_BASE + index_i, READ_TAG, OPC_READ};
      default:    instr_o = INSTR_NOP;
    endcase
  end

endmodule

// File: rtl/tensor_core_host_sequencer.sv
// rtl/tensor_core_host_sequencer.sv - job sequencer: load operands, operate, wait, read back (HOST_CLEAR_ON_START_EN adds CLEAR)
module tensor_core_host_sequencer
  import tensor_host_pkg::*;
(
  input logic                          clock_in,
  input logic                          reset_n_in,
  tensor_core_host_sequencer_if.slave  bus
);

  state_t             state_q, state_d;
  logic [4:0]         index_q, index_d;
  logic [OPSEL_W-1:0] opsel_q, opsel_d;
  logic [71:0]        operand_a_q, operand_a_d;
  logic [71:0]        operand_b_q, operand_b_d;
  logic [71:0]        result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic [15:0]        instruction_q, instruction_d;
  logic [7:0]         load_data;

  // Next state, phase index, operand capture and result capture
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    opsel_d        = opsel_q;
    operand_a_d    = operand_a_q;
    operand_b_d    = operand_b_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          opsel_d        = bus.operation_select_in;
          operand_a_d    = bus.operand_a_in;
          operand_b_d    = bus.operand_b_in;
          result_valid_d = 1'b0;
          index_d        = 5'd0;
`ifdef HOST_CLEAR_ON_START_EN
          state_d        = ST_CLEAR;
`else
          state_d        = ST_LOAD;
`endif
        end
      end
`ifdef HOST_CLEAR_ON_START_EN
      ST_CLEAR: begin
        state_d = ST_LOAD;
        index_d = 5'd0;
      end
`endif
      ST_LOAD: begin
        if (index_q == LOAD_LAST) begin
          state_d = ST_OPERATE;
          index_d = 5'd0;
        end else begin
          index_d = index_q + 5'd1;
        end
      end
      ST_OPERATE: begin
        state_d = ST_WAIT;
        index_d = 5'd0;
      end
      ST_WAIT: begin
        if (index_q == WAIT_LAST) begin
          state_d = ST_READ;
          index_d = 5'd0;
        end else begin
          index_d = index_q + 5'd1;
        end
      end
      ST_READ: begin
        for (int k = 0; k < NUM_ELEMS; k++) begin
          if (index_q == 5'(k)) result_d[k*8 +: 8] = bus.cpu_output_in;
        end
        if (index_q == READ_LAST) begin
          state_d        = ST_DONE;
          index_d        = 5'd0;
          result_valid_d = 1'b1;
        end else begin
          index_d = index_q + 5'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand byte for the upcoming LOAD; uses the _d operands so the first LOAD sees freshly captured data
  always_comb begin
    load_data = 8'h00;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      if (index_d == ADDR_A_BASE + 5'(k)) load_data = operand_a_d[k*8 +: 8];
      if (index_d == ADDR_B_BASE + 5'(k)) load_data = operand_b_d[k*8 +: 8];
    end
  end

  tensor_instruction_encoder u_encoder (
    .state_i (state_d),
    .index_i (index_d),
    .data_i  (load_data),
    .opsel_i (opsel_d),
    .instr_o (instruction_d)
  );

  // State and datapath registers; the instruction is registered alongside its state
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q        <= ST_IDLE;
      index_q        <= 5'd0;
      opsel_q        <= '0;
      operand_a_q    <= '0;
      operand_b_q    <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      instruction_q  <= INSTR_NOP;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      opsel_q        <= opsel_d;
      operand_a_q    <= operand_a_d;
      operand_b_q    <= operand_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      instruction_q  <= instruction_d;
    end
  end

  assign bus.instruction_out  = instruction_q;
  assign bus.busy_out         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done_out         = (state_q == ST_DONE);
  assign bus.result_out       = result_q;
  assign bus.result_valid_out = result_valid_q;

endmodule

// File: tb/tb_tensor_core_host_sequencer.sv
// tb/tb_tensor_core_host_sequencer.sv - directed self-checking bench (HOST_CLEAR_ON_START_EN shifts timing by one)
module tb_tensor_core_host_sequencer;

`ifdef HOST_CLEAR_ON_START_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  localparam int RUN_CYCLES = 60;

  logic clock_in = 1'b0;
  logic reset_n_in;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] words [0:63];
  logic        busy_at [0:63];
  int          done_cycle;
  int          done_count;
  logic [71:0] result_c1;
  logic        valid_c1;
  logic [7:0]  cpu_ret [0:8];

  always #5 clock_in = ~clock_in;

  tensor_core_host_sequencer_if bus ();

  tensor_core_host_sequencer dut (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .bus        (bus)
  );

  // cpu model: answer a READ word with the table entry for its address
  always_comb begin
    int addr;
    addr = int'(bus.instruction_out[10:6]);
    bus.cpu_output_in = 8'h00;
    if (bus.instruction_out[5:0] == 6'b100000 && bus.instruction_out[15:11] == 5'd0 && addr < 9)
      bus.cpu_output_in = cpu_ret[addr];
  end

  function automatic logic [15:0] exp_word(input int c, input logic [71:0] a, input logic [71:0] b,
                                           input logic [2:0] op);
    int k;
    int i;
    logic [7:0] byte_v;
    logic [4:0] addr;
    k = c - CLR;
    if (CLR == 1 && c == 1) return 16'h000C;
    if (k >= 1 && k <= 18) begin
      i = k - 1;
      byte_v = (i < 9) ? a[i*8 +: 8] : b[(i-9)*8 +: 8];
      addr = 5'(i);
      return {addr, byte_v, 3'b001};
    end
    if (k == 19) return {11'b0, op, 2'b10};
    if (k >= 25 && k <= 33) begin
      addr = 5'(k - 25);
      return {5'b0, addr, 6'b100000};
    end
    return 16'h0000;
  endfunction

  task automatic run_job(input logic [71:0] a, input logic [71:0] b, input logic [2:0] op,
                         input logic [63:0] pulse_mask);
    @(negedge clock_in);
    bus.operand_a_in        = a;
    bus.operand_b_in        = b;
    bus.operation_select_in = op;
    bus.start_in            = 1'b1;
    @(posedge clock_in);
    @(negedge clock_in);
    done_cycle = 0;
    done_count = 0;
    for (int c = 1; c <= RUN_CYCLES; c++) begin
      words[c]   = bus.instruction_out;
      busy_at[c] = bus.busy_out;
      if (c == 1) begin
        result_c1 = bus.result_out;
        valid_c1  = bus.result_valid_out;
      end
      if (bus.done_out) begin
        done_count++;
        if (done_cycle == 0) done_cycle = c;
      end
      bus.start_in = pulse_mask[c];
      @(negedge clock_in);
    end
    bus.start_in = 1'b0;
  endtask

  task automatic test_reset;
    reset_n_in = 1'b0;
    repeat (3) @(negedge clock_in);
    checks++; if (bus.instruction_out !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h exp 0000", bus.instruction_out); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy_out); end
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done_out); end
    checks++; if (bus.result_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.result_valid_out); end
    checks++; if (bus.result_out !== 72'h0) begin errors++; $display("FAIL rst_result got %h exp 0", bus.result_out); end
    reset_n_in = 1'b1;
    repeat (2) @(negedge clock_in);
    checks++; if (bus.instruction_out !== 16'h0000) begin errors++; $display("FAIL idle_instr got %h exp 0000", bus.instruction_out); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy_out); end
  endtask

  task automatic test_identity;
    logic [71:0] a;
    logic [71:0] b;
    a = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    b = {9{8'h02}};
    for (int k = 0; k < 9; k++) cpu_ret[k] = 8'h02;
    run_job(a, b, 3'b000, 64'h0);
`ifdef HOST_CLEAR_ON_START_EN
    checks++; if (words[1] !== 16'h000C) begin errors++; $display("FAIL id_clear got %h exp 000C", words[1]); end
`endif
    checks++; if (words[1+CLR] !== 16'h0009) begin errors++; $display("FAIL id_first_load got %h exp 0009", words[1+CLR]); end
    checks++; if (words[19+CLR] !== 16'h0002) begin errors++; $display("FAIL id_operate got %h exp 0002", words[19+CLR]); end
    checks++; if (words[25+CLR] !== 16'h0020) begin errors++; $display("FAIL id_read0 got %h exp 0020", words[25+CLR]); end
    checks++; if (words[33+CLR] !== 16'h0220) begin errors++; $display("FAIL id_read8 got %h exp 0220", words[33+CLR]); end
    for (int c = 1; c <= RUN_CYCLES; c++) begin
      checks++;
      if (words[c] !== exp_word(c, a, b, 3'b000)) begin
        errors++; $display("FAIL id_word[%0d] got %h exp %h", c, words[c], exp_word(c, a, b, 3'b000));
      end
    end
    checks++; if (done_cycle !== 34 + CLR) begin errors++; $display("FAIL id_latency got %0d exp %0d", done_cycle, 34 + CLR); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL id_done_count got %0d exp 1", done_count); end
    checks++; if (busy_at[1] !== 1'b1) begin errors++; $display("FAIL id_busy_first got %b exp 1", busy_at[1]); end
    checks++; if (busy_at[34+CLR] !== 1'b0) begin errors++; $display("FAIL id_busy_done got %b exp 0", busy_at[34+CLR]); end
    checks++; if (bus.result_out !== {9{8'h02}}) begin errors++; $display("FAIL id_result got %h exp all 02", bus.result_out); end
    checks++; if (bus.result_valid_out !== 1'b1) begin errors++; $display("FAIL id_valid got %b exp 1", bus.result_valid_out); end
  endtask

  task automatic test_negative;
    logic [71:0] a;
    logic [71:0] b;
    a = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h81, 8'hFF};
    b = {8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'hFE};
    cpu_ret[0] = 8'h80; cpu_ret[1] = 8'h7F; cpu_ret[2] = 8'hFF; cpu_ret[3] = 8'h01; cpu_ret[4] = 8'hA5;
    cpu_ret[5] = 8'h5A; cpu_ret[6] = 8'h00; cpu_ret[7] = 8'hC3; cpu_ret[8] = 8'h3C;
    run_job(a, b, 3'b101, 64'h0);
    checks++; if (result_c1 !== {9{8'h02}}) begin errors++; $display("FAIL neg_hold got %h exp all 02", result_c1); end
    checks++; if (valid_c1 !== 1'b0) begin errors++; $display("FAIL neg_valid_clr got %b exp 0", valid_c1); end
    checks++; if (words[1+CLR] !== 16'h07F9) begin errors++; $display("FAIL neg_first_load got %h exp 07F9", words[1+CLR]); end
    checks++; if (words[10+CLR] !== 16'h4FF1) begin errors++; $display("FAIL neg_b0_load got %h exp 4FF1", words[10+CLR]); end
    checks++; if (words[19+CLR] !== 16'h0016) begin errors++; $display("FAIL neg_operate got %h exp 0016", words[19+CLR]); end
    checks++; if (bus.result_out[7:0] !== 8'h80) begin errors++; $display("FAIL neg_r0 got %h exp 80", bus.result_out[7:0]); end
    checks++;
    if (bus.result_out !== 72'h3CC3005AA501FF7F80) begin
      errors++; $display("FAIL neg_result got %h exp 3cc3005aa501ff7f80", bus.result_out);
    end
  endtask

  task automatic test_ignored_start;
    logic [71:0] a;
    logic [71:0] b;
    logic [63:0] mask;
    a = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    b = {8'hF7, 8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    mask = 64'h0;
    mask[8+CLR]  = 1'b1;
    mask[21+CLR] = 1'b1;
    mask[34+CLR] = 1'b1;
    for (int k = 0; k < 9; k++) cpu_ret[k] = 8'(k + 16);
    run_job(a, b, 3'b011, mask);
    checks++; if (done_count !== 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", done_count); end
    checks++; if (done_cycle !== 34 + CLR) begin errors++; $display("FAIL ign_latency got %0d exp %0d", done_cycle, 34 + CLR); end
    checks++; if (busy_at[35+CLR] !== 1'b0) begin errors++; $display("FAIL ign_after_done_busy got %b exp 0", busy_at[35+CLR]); end
    for (int c = 1; c <= RUN_CYCLES; c++) begin
      checks++;
      if (words[c] !== exp_word(c, a, b, 3'b011)) begin
        errors++; $display("FAIL ign_word[%0d] got %h exp %h", c, words[c], exp_word(c, a, b, 3'b011));
      end
    end
    checks++;
    if (bus.result_out !== 72'h181716151413121110) begin
      errors++; $display("FAIL ign_result got %h exp 181716151413121110", bus.result_out);
    end
  endtask

  task automatic test_mid_reset;
    logic [71:0] a;
    logic [71:0] b;
    int dones;
    a = {9{8'h03}};
    b = {9{8'h04}};
    for (int k = 0; k < 9; k++) cpu_ret[k] = 8'h55;
    @(negedge clock_in);
    bus.operand_a_in = a; bus.operand_b_in = b; bus.operation_select_in = 3'b001; bus.start_in = 1'b1;
    @(posedge clock_in);
    @(negedge clock_in);
    bus.start_in = 1'b0;
    for (int c = 1; c < 29 + CLR; c++) @(negedge clock_in);
    checks++; if (bus.instruction_out !== 16'h0120) begin errors++; $display("FAIL mr_read4 got %h exp 0120", bus.instruction_out); end
    reset_n_in = 1'b0;
    #1;
    checks++; if (bus.instruction_out !== 16'h0000) begin errors++; $display("FAIL mr_instr got %h exp 0000", bus.instruction_out); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", bus.busy_out); end
    checks++; if (bus.result_out !== 72'h0) begin errors++; $display("FAIL mr_result got %h exp 0", bus.result_out); end
    dones = 0;
    repeat (3) begin
      @(negedge clock_in);
      if (bus.done_out) dones++;
    end
    reset_n_in = 1'b1;
    repeat (8) begin
      @(negedge clock_in);
      if (bus.done_out) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mr_no_done got %0d exp 0", dones); end
    run_job(a, b, 3'b001, 64'h0);
    checks++; if (words[1+CLR] !== 16'h0019) begin errors++; $display("FAIL mr_restart_load got %h exp 0019", words[1+CLR]); end
    checks++; if (done_cycle !== 34 + CLR) begin errors++; $display("FAIL mr_latency got %0d exp %0d", done_cycle, 34 + CLR); end
    checks++; if (bus.result_out !== {9{8'h55}}) begin errors++; $display("FAIL mr_result2 got %h exp all 55", bus.result_out); end
  endtask

  initial begin
    bus.start_in            = 1'b0;
    bus.operation_select_in = 3'b000;
    bus.operand_a_in        = 72'h0;
    bus.operand_b_in        = 72'h0;
    for (int k = 0; k < 9; k++) cpu_ret[k] = 8'h00;
    test_reset();
    test_identity();
    test_negative();
    test_ignored_start();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
